// File: rtl/carfield_ext_mst_arb.sv
// carfield_ext_mst_arb
// --------------------
// Burst-locked round-robin arbiter that funnels the external master ports of
// the safety island, PULP cluster and Spatz cluster onto one serial-link
// master. A grant is taken in IDLE, held for the whole burst in LOCKED, and
// released on the last-beat handshake. The number of bursts whose response is
// still pending is tracked, and no new grant is issued once MaxOutst is reached.
//
// Build option:
//   CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN - when defined, requester 0 (safety
//   island) wins every IDLE arbitration it takes part in; the rest share
//   round robin. When undefined, all requesters are in pure round robin.
//
// Ports:
//   clk_i, rst_ni  clock (rising edge), asynchronous active-low reset
//   req_valid_i    per-requester beat valid
//   req_data_i     per-requester beat payload
//   req_last_i     per-requester last beat of burst
//   req_ready_o    per-requester beat accepted (only the locked one can be high)
//   mst_valid_o    muxed beat valid toward the serial link
//   mst_ready_i    serial link accepts the beat
//   mst_data_o     muxed payload
//   mst_last_o     muxed last flag
//   mst_idx_o      index of the granted requester (held between bursts)
//   rsp_done_i     one-cycle pulse: one burst response completed
//   outst_o        bursts issued whose response is still pending
//   busy_o         LOCKED, or responses still pending
//   dbg_state_o    FSM state (0 IDLE, 1 LOCKED)
//
// Handshake: a beat transfers on a rising edge where mst_valid_o and
// mst_ready_i are both high; req_ready_o of the locked requester mirrors
// mst_ready_i, so the requester-side and master-side transfers are the same
// event. Valid may drop mid-burst; the lock is kept without timeout.

module carfield_ext_mst_arb #(
  parameter int NumReq    = 3,
  parameter int DataWidth = 64,
  parameter int MaxOutst  = 8,
  localparam int IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int OutW     = $clog2(MaxOutst + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_valid_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]                  req_last_i,
  output logic [NumReq-1:0]                  req_ready_o,
  output logic                               mst_valid_o,
  input  logic                               mst_ready_i,
  output logic [DataWidth-1:0]               mst_data_o,
  output logic                               mst_last_o,
  output logic [IdxW-1:0]                    mst_idx_o,
  input  logic                               rsp_done_i,
  output logic [OutW-1:0]                    outst_o,
  output logic                               busy_o,
  output logic                               dbg_state_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [OutW-1:0] outst_q, outst_d;

  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] cand;
  logic            can_issue;
  logic            last_hs;
  logic            dec;

  // Round-robin search: start one past the last winner and wrap at NumReq-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % NumReq);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`ifdef CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN
    // Safety island overrides the rotation whenever it asks.
    if (req_valid_i[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
`endif
  end

  assign can_issue = (outst_q < OutW'(MaxOutst));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    mst_valid_o = 1'b0;
    mst_last_o  = 1'b0;
    req_ready_o = '0;
    last_hs     = 1'b0;
    mst_data_o  = req_data_i[idx_q];

    unique case (state_q)
      IDLE: begin
        if (gnt_found && can_issue) begin
          state_d = LOCKED;
          idx_d   = gnt_idx;
        end
      end
      LOCKED: begin
        mst_valid_o        = req_valid_i[idx_q];
        mst_last_o         = req_last_i[idx_q];
        req_ready_o[idx_q] = mst_ready_i;
        if (mst_valid_o && mst_ready_i && mst_last_o) begin
          last_hs  = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A response can only retire a burst that is actually pending; a
  // simultaneous issue and retire leave the count unchanged.
  always_comb begin
    outst_d = outst_q;
    dec     = rsp_done_i && (outst_q != '0);
    if (last_hs && !dec) begin
      outst_d = outst_q + OutW'(1);
    end else if (!last_hs && dec) begin
      outst_d = outst_q - OutW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= IdxW'(NumReq - 1);
      idx_q    <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      outst_q  <= outst_d;
    end
  end

  assign mst_idx_o   = idx_q;
  assign outst_o     = outst_q;
  assign busy_o      = (state_q == LOCKED) || (outst_q != '0);
  assign dbg_state_o = (state_q == LOCKED);

endmodule

// File: tb/tb_carfield_ext_mst_arb.sv
// Bench for carfield_ext_mst_arb with NumReq=3, DataWidth=16, MaxOutst=2.

module tb_carfield_ext_mst_arb;

  localparam int NR = 3;
  localparam int DW = 16;
  localparam int MO = 2;
  localparam int IW = 2;
  localparam int OW = 2;
  localparam int SW = IW + DW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0]          req_last;
  logic [NR-1:0]          req_ready;
  logic                   mst_valid;
  logic                   mst_ready;
  logic [DW-1:0]          mst_data;
  logic                   mst_last;
  logic [IW-1:0]          mst_idx;
  logic                   rsp_done;
  logic [OW-1:0]          outst;
  logic                   busy;
  logic                   dbg_state;

  carfield_ext_mst_arb #(
    .NumReq   (NR),
    .DataWidth(DW),
    .MaxOutst (MO)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .mst_valid_o(mst_valid),
    .mst_ready_i(mst_ready),
    .mst_data_o (mst_data),
    .mst_last_o (mst_last),
    .mst_idx_o  (mst_idx),
    .rsp_done_i (rsp_done),
    .outst_o    (outst),
    .busy_o     (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: either nobody owns the link or one requester does; the
  // last owner seeds the rotation; pending responses are a plain counter.
  logic       m_locked;
  logic [1:0] m_own;
  logic [1:0] m_last;
  logic [1:0] m_idx;
  int         m_outst;

  task automatic model_reset();
    m_locked = 1'b0;
    m_own    = 2'd0;
    m_last   = 2'(NR - 1);
    m_idx    = 2'd0;
    m_outst  = 0;
  endtask

  task automatic pick_winner(output logic found, output logic [1:0] w);
    found = 1'b0;
    w     = 2'd0;
    if (m_outst >= MO) return;
`ifdef CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN
    if (req_valid[0]) begin
      found = 1'b1;
      return;
    end
`endif
    for (int k = 1; k <= NR; k++) begin
      if (!found && req_valid[(int'(m_last) + k) % NR]) begin
        found = 1'b1;
        w     = 2'((int'(m_last) + k) % NR);
      end
    end
  endtask

  task automatic model_update();
    logic       hs_last;
    logic       dec;
    logic       found;
    logic [1:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hs_last = m_locked && req_valid[m_own] && mst_ready && req_last[m_own];
    dec     = rsp_done && (m_outst > 0);
    if (!m_locked) begin
      pick_winner(found, w);
      if (found) begin
        m_locked = 1'b1;
        m_own    = w;
        m_idx    = w;
      end
    end else if (hs_last) begin
      m_last   = m_own;
      m_locked = 1'b0;
    end
    if (hs_last) m_outst++;
    if (dec) m_outst--;
  endtask

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  logic          sb_en = 1'b1;

  task automatic sb_check();
    logic [SW-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_unexpected: got beat idx %0d data %0h, required none", mst_idx, mst_data);
    end else begin
      e = exp_q.pop_front();
      chk("sb_beat", 32'({mst_idx, mst_data}), 32'(e));
    end
  endtask

  // ---------------- per-requester drivers ----------------
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic [DW:0] q2[$];
  logic [NR-1:0] gap;
  logic [NR-1:0] hs;
  logic          use_drv  = 1'b1;
  logic          rsp_auto = 1'b0;

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int qtotal();
    return q0.size() + q1.size() + q2.size();
  endfunction

  function automatic logic [DW:0] qfront(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int i, input logic [DW:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic drive_from_queues();
    for (int i = 0; i < NR; i++) begin
      if (qsize(i) > 0 && !gap[i]) begin
        {req_last[i], req_data[i]} = qfront(i);
        req_valid[i] = 1'b1;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i]  = '0;
      end
    end
  endtask

  // ---------------- cycle engine ----------------
  task automatic half_a();
    logic       exp_valid;
    logic [2:0] exp_rdy;
    @(negedge clk);
    exp_valid = m_locked && req_valid[m_own];
    exp_rdy   = '0;
    if (m_locked && mst_ready) exp_rdy[m_own] = 1'b1;
    chk("mst_valid", 32'(mst_valid), 32'(exp_valid));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("mst_idx", 32'(mst_idx), 32'(m_idx));
    chk("outst", 32'(outst), m_outst);
    chk("busy", 32'(busy), 32'(m_locked || (m_outst > 0)));
    chk("state", 32'(dbg_state), 32'(m_locked));
    if (exp_valid) begin
      chk("mst_data", 32'(mst_data), 32'(req_data[m_own]));
      chk("mst_last", 32'(mst_last), 32'(req_last[m_own]));
    end
    hs = req_valid & req_ready;
    if (sb_en && mst_valid && mst_ready) sb_check();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) qpop(i);
    end
    #1;
  endtask

  task automatic cycle();
    if (use_drv) drive_from_queues();
    if (rsp_auto) rsp_done = 1'b1;
    half_a();
    half_b();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    rsp_done  = 1'b0;
    mst_ready = 1'b1;
    gap       = '0;
    rsp_auto  = 1'b0;
    use_drv   = 1'b1;
    sb_en     = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    exp_q.delete();
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (qtotal() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_drained"}, 32'(qtotal()), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0] valid;
    logic       rdy;
    logic       rsp;
    logic       e_valid;
    logic [1:0] e_idx;
    logic [2:0] e_rdy;
    logic [1:0] e_outst;
    logic       e_busy;
  } vec_t;

  vec_t tbl[10];

  // ---------------- stimulus ----------------
  initial begin
    int len;
    int added;
    int gapped;
    int n;

    tbl[0] = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0};
    tbl[1] = '{3'b111, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 2'd0, 1'b1};
    tbl[2] = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001, 2'd0, 1'b1};
    tbl[3] = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 2'd1, 1'b1};
    tbl[4] = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 2'd0, 1'b1};
    tbl[5] = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd1, 3'b000, 2'd1, 1'b1};
    tbl[6] = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd2, 3'b100, 2'd0, 1'b1};
    tbl[7] = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd2, 3'b000, 2'd1, 1'b1};
    tbl[8] = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001, 2'd0, 1'b1};
    tbl[9] = '{3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 2'd1, 1'b1};

    do_reset();

`ifndef CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN
    // Round robin 0,1,2,0 with single-beat bursts, one stall, responses mixed in.
    use_drv  = 1'b0;
    req_last = 3'b111;
    for (int i = 0; i < NR; i++) req_data[i] = 16'(16'hC000 + i);
    exp_q.push_back({2'd0, 16'hC000});
    exp_q.push_back({2'd1, 16'hC001});
    exp_q.push_back({2'd2, 16'hC002});
    exp_q.push_back({2'd0, 16'hC000});
    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].valid;
      mst_ready = tbl[v].rdy;
      rsp_done  = tbl[v].rsp;
      half_a();
      chk("tbl_valid", 32'(mst_valid), 32'(tbl[v].e_valid));
      chk("tbl_idx", 32'(mst_idx), 32'(tbl[v].e_idx));
      chk("tbl_ready", 32'(req_ready), 32'(tbl[v].e_rdy));
      chk("tbl_outst", 32'(outst), 32'(tbl[v].e_outst));
      chk("tbl_busy", 32'(busy), 32'(tbl[v].e_busy));
      half_b();
    end
    chk("tbl_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    // 4-beat burst from requester 1 stays contiguous; requester 0 joins at beat 2.
    do_reset();
    rsp_auto = 1'b1;
    for (int b = 0; b < 4; b++) begin
      qpush(1, {(b == 3), 16'(16'h1100 + b)});
      exp_q.push_back({2'd1, 16'(16'h1100 + b)});
    end
    exp_q.push_back({2'd0, 16'h0B0B});
    added  = 0;
    gapped = 0;
    n      = 0;
    while (qtotal() > 0 && n < 40) begin
      gap[1] = (q1.size() == 3) && (gapped == 0);
      if (gap[1]) gapped = 1;
      cycle();
      gap[1] = 1'b0;
      if (added == 0 && q1.size() == 2) begin
        qpush(0, {1'b1, 16'h0B0B});
        added = 1;
      end
      n++;
    end
    chk("lock_drained", 32'(qtotal()), 32'd0);
    chk("lock_sb_empty", 32'(exp_q.size()), 32'd0);

    // Outstanding limit reached: no grant until one response retires.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      qpush(i, {1'b1, 16'(16'h5500 + i)});
      exp_q.push_back({2'(i), 16'(16'h5500 + i)});
    end
    for (int c = 0; c < 4; c++) cycle();
    for (int c = 0; c < 3; c++) begin
      drive_from_queues();
      #1;
      chk("max_outst", 32'(outst), 32'd2);
      chk("max_no_valid", 32'(mst_valid), 32'd0);
      chk("max_no_ready", 32'(req_ready), 32'd0);
      chk("max_busy", 32'(busy), 32'd1);
      cycle();
    end
    rsp_done = 1'b1;
    cycle();
    rsp_done = 1'b0;
    drive_from_queues();
    #1;
    chk("max_after_rsp_outst", 32'(outst), 32'd1);
    chk("max_after_rsp_idle", 32'(mst_valid), 32'd0);
    cycle();
    drive_from_queues();
    #1;
    chk("max_regrant_valid", 32'(mst_valid), 32'd1);
    chk("max_regrant_idx", 32'(mst_idx), 32'd2);
    drain("max", 20);

    // Issue and retire in the same cycle; retire at zero is ignored.
    do_reset();
    qpush(0, {1'b1, 16'h7700});
    qpush(1, {1'b1, 16'h7701});
    exp_q.push_back({2'd0, 16'h7700});
    exp_q.push_back({2'd1, 16'h7701});
    for (int c = 0; c < 3; c++) cycle();
    rsp_done = 1'b1;
    drive_from_queues();
    #1;
    chk("same_cyc_last_hs", 32'(mst_valid && mst_last && mst_ready), 32'd1);
    chk("same_cyc_before", 32'(outst), 32'd1);
    cycle();
    drive_from_queues();
    #1;
    chk("same_cyc_after", 32'(outst), 32'd1);
    cycle();
    drive_from_queues();
    #1;
    chk("retire_to_zero", 32'(outst), 32'd0);
    cycle();
    drive_from_queues();
    #1;
    chk("no_underflow", 32'(outst), 32'd0);
    rsp_done = 1'b0;
    chk("same_cyc_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during beat 2 of a 3-beat burst.
    do_reset();
    qpush(1, {1'b1, 16'h3300});
    exp_q.push_back({2'd1, 16'h3300});
    for (int b = 0; b < 3; b++) qpush(2, {(b == 2), 16'(16'h3400 + b)});
    exp_q.push_back({2'd2, 16'h3400});
    for (int c = 0; c < 4; c++) cycle();
    drive_from_queues();
    #1;
    chk("pre_rst_valid", 32'(mst_valid), 32'd1);
    chk("pre_rst_outst", 32'(outst), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(mst_valid), 32'd0);
    chk("rst_outst", 32'(outst), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(mst_idx), 32'd0);
    chk("rst_sb_empty", 32'(exp_q.size()), 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    model_reset();
    cycle();
    cycle();
    rst_n    = 1'b1;
    rsp_auto = 1'b1;
    for (int i = 0; i < NR; i++) begin
      qpush(i, {1'b1, 16'(16'h6600 + i)});
      exp_q.push_back({2'(i), 16'(16'h6600 + i)});
    end
    drain("post_rst", 30);

`ifdef CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN
    // Safety island keeps winning while it has work.
    do_reset();
    rsp_auto = 1'b1;
    for (int b = 0; b < 4; b++) begin
      qpush(0, {1'b1, 16'(16'h0A00 + b)});
      qpush(2, {1'b1, 16'(16'h2A00 + b)});
    end
    for (int b = 0; b < 4; b++) exp_q.push_back({2'd0, 16'(16'h0A00 + b)});
    for (int b = 0; b < 4; b++) exp_q.push_back({2'd2, 16'(16'h2A00 + b)});
    drain("prio", 60);
`endif

    // Randomized traffic against the model.
    do_reset();
    sb_en = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (qsize(i) == 0 && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) qpush(i, {(b == len - 1), 16'($urandom)});
        end
        gap[i] = ($urandom_range(0, 5) == 0);
      end
      mst_ready = ($urandom_range(0, 3) != 0);
      rsp_done  = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/carfield_ext_mst_arb.md
CARFIELD_EXT_MST_ARB -- requirements
Module: carfield_ext_mst_arb

Interface
REQ-001 SHALL have parameter NumReq, default 3, number of requesters (safety island, PULP cluster, Spatz cluster).
REQ-002 SHALL have parameter DataWidth, default 64, request payload width.
REQ-003 SHALL have parameter MaxOutst, default 8, maximum outstanding bursts (at least 1).
REQ-004 SHALL have clk_i  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have req_valid_i  in  NumReq  per-requester beat valid.
REQ-007 SHALL have req_data_i  in  NumReq x DataWidth  per-requester beat payload.
REQ-008 SHALL have req_last_i  in  NumReq  marks last beat of a burst.
REQ-009 SHALL have req_ready_o  out  NumReq  per-requester beat accepted.
REQ-010 SHALL have mst_valid_o / mst_ready_i  out / in  1 / 1  muxed beat handshake toward the serial link.
REQ-011 SHALL have mst_data_o  out  DataWidth  muxed payload.
REQ-012 SHALL have mst_last_o  out  1  muxed last flag.
REQ-013 SHALL have mst_idx_o  out  clog2(NumReq), minimum 1  index of the granted requester.
REQ-014 SHALL have rsp_done_i  in  1  pulse: one burst response completed.
REQ-015 SHALL have outst_o  out  clog2(MaxOutst+1)  current outstanding count.
REQ-016 SHALL have busy_o  out  1  high when in LOCKED state or outst_o is non-zero.

Function
REQ-017 SHALL use FSM states IDLE and LOCKED.
REQ-018 SHALL, in IDLE, grant the next requester with req_valid_i high after rr_ptr in round-robin order, provided outst_o < MaxOutst; it then enters LOCKED in the next cycle with grant registered.
REQ-019 SHALL, in IDLE, drive mst_valid_o and all req_ready_o low; grant costs one cycle of latency.
REQ-020 SHALL, in LOCKED, drive mst_valid_o, mst_data_o and mst_last_o combinationally from the granted requester, set only that requester's req_ready_o equal to mst_ready_i, and hold mst_idx_o stable.
REQ-021 SHALL leave LOCKED for IDLE on a handshake with mst_last_o high, and set rr_ptr to the granted index in the same edge.
REQ-022 SHALL keep the lock while req_valid_i drops mid-burst, with no regrant and no timeout.
REQ-023 SHALL increment outst_o on a last-beat handshake and decrement it on rsp_done_i.
REQ-024 SHALL leave outst_o unchanged when increment and decrement occur in the same cycle.
REQ-025 SHALL ignore rsp_done_i when outst_o is 0 (no underflow).
REQ-026 SHALL issue no new grant while outst_o equals MaxOutst; a burst already LOCKED completes.
REQ-027 SHALL wrap round-robin search from index NumReq-1 to 0.
REQ-028 SHALL stay in IDLE when no requester is valid, with rr_ptr unchanged.

Reset
REQ-029 SHALL, while rst_ni is low: state IDLE, rr_ptr NumReq-1 (index 0 wins first), outst_o 0, mst_idx_o 0, mst_valid_o 0, req_ready_o all 0, busy_o 0.
REQ-030 SHALL, on reset assertion mid-burst, abort the burst immediately with no completion beat.

Configuration
REQ-031 SHALL, with macro CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN defined, grant requester 0 (safety island) whenever it is valid in IDLE, overriding round robin and still subject to REQ-026; other requesters use round robin among themselves.
REQ-032 SHALL, without CARFIELD_EXT_MST_ARB_SAFED_PRIO_EN, use pure round robin across all requesters.

Verification
REQ-033 SHALL test all three requesters valid with single-beat bursts, mst_ready_i=1 -> grant order 0,1,2,0 and mst_idx_o matches each beat (macro undefined).
REQ-034 SHALL test requester 1 driving a 4-beat burst while requester 0 becomes valid at beat 2 -> all 4 beats from index 1 contiguous, then index 0 granted.
REQ-035 SHALL test MaxOutst=2 with 2 bursts completed and no rsp_done_i -> outst_o=2, no grant; one rsp_done_i pulse -> grant on the next IDLE cycle.
REQ-036 SHALL test a last-beat handshake and rsp_done_i in the same cycle at outst_o=1 -> outst_o stays 1; rsp_done_i at outst_o=0 -> stays 0.
REQ-037 SHALL test rst_ni pulled low during beat 2 of a 3-beat burst -> mst_valid_o=0 and outst_o=0 immediately; after release index 0 is granted first.
REQ-038 SHALL test, with the macro defined, requesters 0 and 2 continuously valid with single beats -> index 0 granted every burst.
